barrel_shift32: RTL and testbench

- 32-bit logical barrel shifter with a registered output. Shifts data word D left or right by S bit positions.
- Used as the shift unit beside the ALU in the 32-bit datapath. It serves SLL/SRL-style operations where the shift amount comes from a full 32-bit operand.
- The combinational core is a 5-stage log-shifter (shift by 1/2/4/8/16). A 32-bit output register follows the core.

---
 rtl/barrel_shift32.sv | 67 ++++++
 tb/tb_barrel_shift32.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift32.sv
// barrel_shift32: 32-bit logical barrel shifter with a registered output.
// A five-stage log-shifter (1/2/4/8/16) computes the result, and a 32-bit
// register captures it on every rising clock edge. Left shifts reuse the
// right-shift network by bit-reversing the operand and then the result.
// Any shift amount of WIDTH or more yields zero in both directions.
module barrel_shift32 #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] S,
  input  logic             LnR,
  output logic [WIDTH-1:0] Y
);

  // Mirror a word end-for-end, so bit 0 swaps with bit WIDTH-1.
  function automatic logic [WIDTH-1:0] bit_reverse(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) begin
      r[i] = v[WIDTH-1-i];
    end
    return r;
  endfunction

  // stage[0] is the direction-normalised operand. stage[k+1] is stage[k],
  // shifted right by 2**k when S[k] is set.
  logic [STAGES:0][WIDTH-1:0] stage;
  logic                       big_shift;
  logic [WIDTH-1:0]           y_d;
  logic [WIDTH-1:0]           y_q;

  // A left shift is a right shift done on the bit-reversed word.
  assign stage[0] = LnR ? bit_reverse(D) : D;

  // Any set bit above the mux-select bits means S >= WIDTH.
  assign big_shift = |S[WIDTH-1:STAGES];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    assign stage[k+1] = S[k] ? (stage[k] >> (1 << k)) : stage[k];
  end

  // Undo the input reversal for left shifts and force zero for big shifts.
  always_comb begin
    // NOTE: give every always_comb output a default first. Otherwise a path
    // that does not assign it infers a latch.
    y_d = '0;
    if (!big_shift) begin
      y_d = LnR ? bit_reverse(stage[STAGES]) : stage[STAGES];
    end
  end

  // Output register: loaded every cycle, cleared asynchronously by reset.
  always_ff @(posedge CLK or negedge RST) begin
    // NOTE: use non-blocking (<=) for flop state. Blocking assignments here
    // create ordering races between clocked processes.
    if (!RST) begin
      y_q <= '0;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_barrel_shift32.sv
// Testbench for barrel_shift32. The stimulus side pushes each expected result
// into a queue. A monitor pops one entry per rising edge and compares it with Y.
module tb_barrel_shift32;

  localparam logic [31:0] PAT = 32'ha5a5a5a5;

  logic        CLK;
  logic        RST;
  logic [31:0] D;
  logic [31:0] S;
  logic        LnR;
  logic [31:0] Y;

  int          n_checks;
  int          n_pass;
  logic [31:0] exp_q[$];
  logic [31:0] last_pushed;

  barrel_shift32 dut (
    .CLK (CLK),
    .RST (RST),
    .D   (D),
    .S   (S),
    .LnR (LnR),
    .Y   (Y)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model. Any amount of 32 or more clears the word; otherwise the
  // result is a plain logical shift in the requested direction.
  function automatic logic [31:0] model(input logic [31:0] d, input logic [31:0] s,
                                        input logic lnr);
    if (s >= 32) return 32'h0;
    return lnr ? (d << s[4:0]) : (d >> s[4:0]);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: away from the edge, compare Y with the oldest expected value.
  always @(posedge CLK) begin
    #1;
    if (RST === 1'b1 && exp_q.size() > 0) begin
      check("scoreboard", Y, exp_q.pop_front());
    end
  end

  // Drive one vector at the falling edge and queue a given expected value.
  task automatic apply_exp(input logic [31:0] d, input logic [31:0] s, input logic lnr,
                           input logic [31:0] exp);
    @(negedge CLK);
    D   = d;
    S   = s;
    LnR = lnr;
    exp_q.push_back(exp);
    last_pushed = exp;
  endtask

  task automatic apply(input logic [31:0] d, input logic [31:0] s, input logic lnr);
    apply_exp(d, s, lnr, model(d, s, lnr));
  endtask

  // Pulse reset low between edges. Y must clear at once and stay clear
  // through an edge and through the release.
  task automatic reset_pulse();
    #2;
    RST = 1'b0;
    exp_q.delete();
    #1;
    check("async_clear", Y, 32'h0);
    @(posedge CLK);
    #1;
    check("held_in_reset", Y, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    #1;
    check("release_no_load", Y, 32'h0);
  endtask

  // Watchdog: the run must always end on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    last_pushed = '0;
    RST = 1'b0;
    D   = PAT;
    S   = 32'd1;
    LnR = 1'b1;

    // Reset with the clock running.
    repeat (3) @(posedge CLK);
    #1;
    check("reset_state", Y, 32'h0);

    // Release at a falling edge. The next rising edge is the first capture.
    @(negedge CLK);
    exp_q.push_back(32'h4b4b4b4a);
    RST = 1'b1;
    #1;
    check("post_release", Y, 32'h0);

    // Spot values, checked against literal constants.
    apply_exp(PAT, 32'd1,  1'b1, 32'h4b4b4b4a);
    apply_exp(PAT, 32'd4,  1'b1, 32'h5a5a5a50);
    apply_exp(PAT, 32'd16, 1'b1, 32'ha5a50000);
    apply_exp(PAT, 32'd31, 1'b1, 32'h80000000);
    apply_exp(PAT, 32'd32, 1'b1, 32'h00000000);
    apply_exp(PAT, 32'd1,  1'b0, 32'h52d2d2d2);
    apply_exp(PAT, 32'd4,  1'b0, 32'h0a5a5a5a);
    apply_exp(PAT, 32'd16, 1'b0, 32'h0000a5a5);
    apply_exp(PAT, 32'd31, 1'b0, 32'h00000001);
    apply_exp(PAT, 32'd32, 1'b0, 32'h00000000);

    // Zero and large amounts, in both directions.
    for (int dir = 0; dir < 2; dir++) begin
      apply_exp(PAT, 32'd0,          dir[0], PAT);
      apply_exp(PAT, 32'd33,         dir[0], 32'h0);
      apply_exp(PAT, 32'hffffffff,   dir[0], 32'h0);
      apply_exp(PAT, 32'h00000040,   dir[0], 32'h0);
      apply_exp(PAT, 32'h80000001,   dir[0], 32'h0);
    end

    // Left sweep, with a reset pulse in the middle of it.
    for (int s = 1; s <= 32; s++) begin
      apply(PAT, s, 1'b1);
      if (s == 10) reset_pulse();
    end

    // Right sweep.
    for (int s = 1; s <= 32; s++) begin
      apply(PAT, s, 1'b0);
    end

    // Hold: S changes between edges. Only the value present at the edge counts.
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      logic [31:0] s1;
      logic [31:0] s2;
      logic        lnr;
      logic [31:0] prev;
      d    = $urandom;
      s1   = $urandom_range(0, 31);
      s2   = $urandom_range(1, 31);
      lnr  = i[0];
      prev = last_pushed;
      @(negedge CLK);
      D   = d;
      S   = s1;
      LnR = lnr;
      #2;
      S = s2;
      exp_q.push_back(model(d, s2, lnr));
      last_pushed = model(d, s2, lnr);
      #1;
      check("hold_mid_cycle", Y, prev);
    end

    // Random vectors: a mix of in-range, boundary and full-width amounts.
    for (int i = 0; i < 300; i++) begin
      logic [31:0] s;
      case ($urandom_range(0, 3))
        0:       s = $urandom_range(0, 31);
        1:       s = $urandom_range(30, 40);
        2:       s = $urandom;
        default: s = 32'(1) << $urandom_range(0, 31);
      endcase
      apply($urandom, s, 1'($urandom_range(0, 1)));
    end

    // Let the last vectors reach the monitor, then confirm nothing is left.
    repeat (3) @(negedge CLK);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
